// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  localparam int ADDR_W         = 32;
  localparam int WORD_BITS      = 32;
  localparam int DEF_NUM_LINES  = 16;
  localparam int DEF_LINE_WORDS = 4;

  function automatic int line_bits(input int line_words);
    return WORD_BITS * line_words;
  endfunction

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Byte offset within a line: word select plus the two byte-in-word bits.
  function automatic int offset_w(input int line_words);
    return word_w(line_words) + 2;
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int line_words);
    return ADDR_W - index_w(num_lines) - offset_w(line_words);
  endfunction

  localparam int LINE_BITS = line_bits(DEF_LINE_WORDS);

endpackage

// File: rtl/dcache_sram.sv
// Cache line storage: valid/dirty/tag/data arrays with one combinational read
// port and one synchronous line write port with per-word enables.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES  = DEF_NUM_LINES,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  localparam int LINE_W     = line_bits(LINE_WORDS),
  localparam int INDEX_W    = index_w(NUM_LINES),
  localparam int TAG_W      = tag_w(NUM_LINES, LINE_WORDS)
)(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [INDEX_W-1:0]    i_rd_idx,
  output logic                  o_rd_valid,
  output logic                  o_rd_dirty,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [LINE_W-1:0]     o_rd_line,
  input  logic                  i_wr_en,
  input  logic [INDEX_W-1:0]    i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic                  i_wr_dirty,
  input  logic [LINE_WORDS-1:0] i_wr_word_en,
  input  logic [LINE_W-1:0]     i_wr_line
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_dirty[i_wr_idx] <= i_wr_dirty;
    end
  end

  // NOTE: tag and data arrays are not reset; a cleared valid bit makes their
  // contents irrelevant, and leaving them unreset lets them map to plain RAM.
  always_ff @(posedge clk_i) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (i_wr_word_en[w]) begin
          r_data[i_wr_idx][WORD_BITS*w +: WORD_BITS] <= i_wr_line[WORD_BITS*w +: WORD_BITS];
        end
      end
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: same-cycle
// hits, pipeline stall on miss while the victim is written back and the line refilled.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES  = DEF_NUM_LINES,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  localparam int LINE_W     = line_bits(LINE_WORDS)
)(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int WORD_W   = word_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(NUM_LINES);
  localparam int TAG_W    = tag_w(NUM_LINES, LINE_WORDS);

  state_e              r_state;
  state_e              w_next_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [LINE_W-1:0]   r_mem_data;

  logic [WORD_W-1:0]   w_word;
  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [31:0]         w_req_line_addr;
  logic [31:0]         w_victim_addr;
  logic                w_unused;

  logic                w_rd_valid;
  logic                w_rd_dirty;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [LINE_W-1:0]   w_rd_line;

  logic                w_req;
  logic                w_hit;
  logic                w_miss;

  logic                w_wr_en;
  logic                w_wr_dirty;
  logic [LINE_WORDS-1:0] w_wr_word_en;
  logic [LINE_W-1:0]   w_wr_line;

  assign w_word   = cpu_addr_i[OFFSET_W-1:2];
  assign w_idx    = cpu_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_tag    = cpu_addr_i[31:OFFSET_W+INDEX_W];
  assign w_unused = ^cpu_addr_i[1:0];

  assign w_req_line_addr = {w_tag, w_idx, {OFFSET_W{1'b0}}};
  assign w_victim_addr   = {w_rd_tag, w_idx, {OFFSET_W{1'b0}}};

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_dirty  (w_rd_dirty),
    .o_rd_tag    (w_rd_tag),
    .o_rd_line   (w_rd_line),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_idx),
    .i_wr_tag    (w_tag),
    .i_wr_dirty  (w_wr_dirty),
    .i_wr_word_en(w_wr_word_en),
    .i_wr_line   (w_wr_line)
  );

  // Qualifying with rst_n_i keeps stall and load data low while reset is held,
  // even if the CPU still presents a request.
  assign w_req  = cpu_req_i & rst_n_i;
  assign w_hit  = w_req & w_rd_valid & (w_rd_tag == w_tag);
  assign w_miss = w_req & ~w_hit;

  // NOTE: every signal gets a default at the top of this block, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    cpu_stall_o  = 1'b0;
    cpu_data_o   = '0;
    w_wr_en      = 1'b0;
    w_wr_dirty   = 1'b0;
    w_wr_word_en = '0;
    w_wr_line    = '0;

    case (r_state)
      IDLE: begin
        if (w_hit) begin
          if (cpu_we_i) begin
            w_wr_en      = 1'b1;
            w_wr_dirty   = 1'b1;
            w_wr_word_en = LINE_WORDS'(1) << w_word;
            w_wr_line    = {LINE_WORDS{cpu_data_i}};
          end else begin
            cpu_data_o = w_rd_line[WORD_BITS*w_word +: WORD_BITS];
          end
        end else if (w_miss) begin
          cpu_stall_o  = 1'b1;
          w_next_state = (w_rd_valid && w_rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        if (mem_ack_i) begin
          w_next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        if (mem_ack_i) begin
          w_wr_en      = 1'b1;
          w_wr_dirty   = 1'b0;
          w_wr_word_en = '1;
          w_wr_line    = mem_data_i;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_mem_req <= 1'b1;
            if (w_rd_valid && w_rd_dirty) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= w_victim_addr;
              r_mem_data <= w_rd_line;
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_req_line_addr;
              r_mem_data <= '0;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_req_line_addr;
            r_mem_data <= '0;
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o  = r_mem_req;
  assign mem_we_o   = r_mem_we;
  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: backing-memory model with programmable
// ack delay, scoreboards for load data and memory transactions.
module tb_dcache_ctrl;

  localparam int NL = 16;
  localparam int LW = 4;
  localparam int LB = 32 * LW;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [LB-1:0] data;
  } txn_t;

  logic          clk;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [LB-1:0] mem_wdata;
  logic [LB-1:0] mem_rdata;
  logic          mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  txn_t          txn_log [64];
  int            txn_cnt   = 0;
  int            txn_rd    = 0;
  int            ack_delay = 0;
  int            wait_cnt  = 0;
  logic [LB-1:0] mem_model [logic [31:0]];

  txn_t        exp_txn_q [$];
  logic [31:0] exp_load_q [$];

  dcache_ctrl #(
    .NUM_LINES (NL),
    .LINE_WORDS(LW)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .cpu_data_o (cpu_rdata),
    .cpu_stall_o(cpu_stall),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .mem_ack_i  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LB-1:0] pat_line(input logic [31:0] a);
    logic [LB-1:0] l;
    for (int k = 0; k < LW; k++) l[32*k +: 32] = {a[15:0], 16'(k)} ^ 32'hC0DE_0000;
    if (a == 32'h0000_0100) l[63:32] = 32'hDEAD_BEEF;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [LB-1:0] l, input int w);
    return l[32*w +: 32];
  endfunction

  function automatic logic [LB-1:0] put_word(input logic [LB-1:0] l, input int w,
                                             input logic [31:0] v);
    logic [LB-1:0] r;
    r = l;
    r[32*w +: 32] = v;
    return r;
  endfunction

  // Backing memory: acks the (ack_delay+1)-th cycle of each request.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst_n && mem_req) begin
      if (wait_cnt == ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : pat_line(mem_addr);
        if (txn_cnt < 64) txn_log[txn_cnt] = '{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata};
        txn_cnt++;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic push_txn(input logic we, input logic [31:0] addr, input logic [LB-1:0] data);
    txn_t t;
    t = '{we, addr, data};
    exp_txn_q.push_back(t);
  endtask

  // Drives one CPU access, holds it through the stall, and scores the result
  // cycle's load data against the head of the load scoreboard.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, output int stalls, output logic mreq_end);
    int          cyc;
    bit          done;
    logic [31:0] rd;
    logic [31:0] exp;
    cyc = 0; done = 0; stalls = 0; mreq_end = 1'b0; rd = '0;
    exp_load_q.push_back(exp_rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (!cpu_stall) begin
        done = 1; rd = cpu_rdata; mreq_end = mem_req;
      end else begin
        stalls++;
      end
    end
    exp = exp_load_q.pop_front();
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL access_timeout addr=%h stalled %0d cycles", addr, cyc);
    end else if (rd !== exp) begin
      n_fail++;
      $display("FAIL load_data addr=%h got=%h exp=%h", addr, rd, exp);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic drain_txns(input string name);
    txn_t e;
    txn_t o;
    while (exp_txn_q.size() > 0) begin
      e = exp_txn_q.pop_front();
      n_tests++;
      if (txn_rd >= txn_cnt) begin
        n_fail++;
        $display("FAIL %s missing txn: got none exp we=%0b addr=%h", name, e.we, e.addr);
      end else begin
        o = txn_log[txn_rd];
        txn_rd++;
        if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
          n_fail++;
          $display("FAIL %s txn got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h",
                   name, o.we, o.addr, o.data, e.we, e.addr, e.data);
        end
      end
    end
    n_tests++;
    if (txn_rd != txn_cnt) begin
      n_fail++;
      $display("FAIL %s extra txns got=%0d exp=%0d", name, txn_cnt, txn_rd);
      txn_rd = txn_cnt;
    end
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got stall=%b req=%b we=%b exp 0/0/0", cpu_stall, mem_req, mem_we);
    end
    n_tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== '0 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%h data=%h rd=%h exp zeros", mem_addr, mem_wdata, cpu_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_load;
    int   st;
    logic mr;
    ack_delay = 3;
    push_txn(1'b0, 32'h0000_0100, '0);
    cpu_access(1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, st, mr);
    n_tests++;
    if (st !== 5) begin n_fail++; $display("FAIL cold_stall got=%0d exp=5", st); end
    drain_txns("cold_load");
  endtask

  task automatic test_hit;
    int   st;
    logic mr;
    cpu_access(1'b0, 32'h0000_0108, 32'h0, word_of(pat_line(32'h100), 2), st, mr);
    n_tests++;
    if (st !== 0 || mr !== 1'b0) begin
      n_fail++; $display("FAIL hit_nostall got stall=%0d req=%b exp 0/0", st, mr);
    end
    drain_txns("hit");
  endtask

  task automatic test_dirty_miss;
    int   st;
    logic mr;
    cpu_access(1'b1, 32'h0000_0104, 32'h1234_5678, 32'h0, st, mr);
    n_tests++;
    if (st !== 0) begin n_fail++; $display("FAIL store_hit_stall got=%0d exp=0", st); end
    push_txn(1'b1, 32'h0000_0100, put_word(pat_line(32'h100), 1, 32'h1234_5678));
    push_txn(1'b0, 32'h0000_0200, '0);
    cpu_access(1'b0, 32'h0000_0204, 32'h0, word_of(pat_line(32'h200), 1), st, mr);
    n_tests++;
    if (st !== 9) begin n_fail++; $display("FAIL dirty_stall got=%0d exp=9", st); end
    drain_txns("dirty_miss");
  endtask

  task automatic test_clean_conflict;
    int   st;
    logic mr;
    push_txn(1'b0, 32'h0000_0300, '0);
    cpu_access(1'b0, 32'h0000_0304, 32'h0, word_of(pat_line(32'h300), 1), st, mr);
    n_tests++;
    if (st !== 5) begin n_fail++; $display("FAIL clean_stall got=%0d exp=5", st); end
    drain_txns("clean_conflict");
  endtask

  task automatic test_zero_wait;
    int   st;
    logic mr;
    ack_delay = 0;
    cpu_access(1'b1, 32'h0000_0304, 32'hA1B2_C3D4, 32'h0, st, mr);
    push_txn(1'b1, 32'h0000_0300, put_word(pat_line(32'h300), 1, 32'hA1B2_C3D4));
    push_txn(1'b0, 32'h0000_0400, '0);
    cpu_access(1'b0, 32'h0000_0404, 32'h0, word_of(pat_line(32'h400), 1), st, mr);
    n_tests++;
    if (st !== 3) begin n_fail++; $display("FAIL zero_wait_stall got=%0d exp=3", st); end
    drain_txns("zero_wait");
    push_txn(1'b0, 32'h0000_0500, '0);
    cpu_access(1'b1, 32'h0000_0508, 32'h55AA_33CC, 32'h0, st, mr);
    n_tests++;
    if (st !== 2) begin n_fail++; $display("FAIL store_miss_stall got=%0d exp=2", st); end
    drain_txns("store_miss");
    cpu_access(1'b0, 32'h0000_0508, 32'h0, 32'h55AA_33CC, st, mr);
    cpu_access(1'b0, 32'h0000_050C, 32'h0, word_of(pat_line(32'h500), 3), st, mr);
  endtask

  task automatic test_back_to_back;
    int   st;
    int   total;
    logic mr;
    ack_delay = 1;
    push_txn(1'b1, 32'h0000_0500, put_word(pat_line(32'h500), 2, 32'h55AA_33CC));
    push_txn(1'b0, 32'h0000_0600, '0);
    cpu_access(1'b0, 32'h0000_0604, 32'h0, word_of(pat_line(32'h600), 1), st, mr);
    n_tests++;
    if (st !== 5) begin n_fail++; $display("FAIL delay1_stall got=%0d exp=5", st); end
    total = 0;
    for (int w = 0; w < LW; w++) begin
      cpu_access(1'b0, 32'h0000_0600 + 32'(4*w), 32'h0, word_of(pat_line(32'h600), w), st, mr);
      total += st;
    end
    n_tests++;
    if (total !== 0) begin n_fail++; $display("FAIL b2b_hits got=%0d stalls exp=0", total); end
    drain_txns("back_to_back");
  endtask

  task automatic test_reset_mid;
    int   st;
    logic mr;
    ack_delay = 10;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0104;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL mid_alloc got req=%b stall=%b we=%b addr=%h exp 1/1/0/00000100",
               mem_req, cpu_stall, mem_we, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got req=%b stall=%b exp 0/0", mem_req, cpu_stall);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack_delay = 2;
    push_txn(1'b0, 32'h0000_0100, '0);
    cpu_access(1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, st, mr);
    n_tests++;
    if (st !== 4) begin n_fail++; $display("FAIL post_reset_stall got=%0d exp=4", st); end
    drain_txns("reset_mid");
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_cold_load();
    test_hit();
    test_dirty_miss();
    test_clean_conflict();
    test_zero_wait();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the CPU's MEM stage and a multi-cycle backing data memory. It replaces the single-cycle data memory port. It answers hits in the same cycle and stalls the pipeline on misses while it writes back a dirty victim and refills the line through a req/ack handshake.

## Interface
- NUM_LINES, 16, number of cache lines (power of 2, ≥2)
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2); LINE_BITS = 32·LINE_WORDS
- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word-aligned (bits [1:0] ignored)
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  freeze the whole pipeline this cycle
- mem_req_o  out  1  backing-memory transaction valid
- mem_we_o  out  1  1 = line write-back, 0 = line read
- mem_addr_o  out  32  line-aligned address (low log2(LINE_BITS/8) bits zero)
- mem_data_o  out  LINE_BITS  write-back line
- mem_data_i  in  LINE_BITS  refill line, valid when mem_ack_i=1
- mem_ack_i  in  1  one-cycle pulse completing the current transaction

## Operation
- Address split: byte bits [1:0]; word select next log2(LINE_WORDS) bits; index next log2(NUM_LINES) bits; tag = remaining upper bits.
- Per-line state: valid, dirty, tag, LINE_BITS data.
- hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, hit, load: cpu_data_o = selected word, combinational; cpu_stall_o=0.
- IDLE, hit, store: the selected word is written at the clock edge; dirty[idx] is set to 1; cpu_stall_o=0.
- IDLE, miss: cpu_stall_o=1 in the same cycle. Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, idx, 0}, mem_data_o=victim line. On mem_ack_i the next state is ALLOCATE.
- ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, idx, 0}. On mem_ack_i:
  - mem_data_i is written into the line; valid=1, dirty=0, tag updated.
  - Next state is IDLE.
- Back in IDLE the held request hits and completes as a normal hit. Stores merge into the refilled line and set dirty.
- cpu_stall_o=1 in every non-IDLE state.
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1.
- cpu_data_o = 0 when there is no load hit.
- mem_ack_i is ignored in IDLE.
- With cpu_req_i=0, the controller stays in IDLE with no stall.

## Timing
- Reset (asynchronous, rst_n_i=0):
  - State goes to IDLE; all valid and dirty bits are cleared. Tag and data contents are don't-care.
  - Outputs: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=0, cpu_data_o=0.
- Hit latency is 0 extra cycles.
- Clean miss costs (ack delay + 1) cycles in ALLOCATE plus 1 IDLE hit cycle.
- Dirty miss additionally costs (ack delay + 1) cycles in WRITEBACK.
- Handshake rules:
  - mem_req_o, mem_we_o, mem_addr_o and mem_data_o are driven from registered state and are stable for the whole transaction.
  - Each cycle with mem_req_o=1 after an acked cycle starts a new transaction. There are no back-to-back acks on the same transaction.
  - An ack may arrive in the first request cycle (0 wait states).
- Reset mid-transaction aborts the transaction immediately. The memory must drop it, and any pending dirty data is lost (by design).
- A store hit and a refill can never coincide: the refill write happens only in ALLOCATE, and stores complete only in IDLE.

## Structure
- dcache_pkg:
  - state enum (IDLE, WRITEBACK, ALLOCATE);
  - localparam functions for OFFSET_W, WORD_W, INDEX_W, TAG_W derived from NUM_LINES/LINE_WORDS;
  - the LINE_BITS constant.
- Sub-module dcache_sram holds the valid/dirty/tag/data arrays. It has one combinational read port and one synchronous write port (line write with word-enable merge) and async-clears valid/dirty on rst_n_i.
- dcache_ctrl holds the FSM, hit logic and the memory-port registers.

## Test plan
All tests use NUM_LINES=16, LINE_WORDS=4: index = addr[7:4], tag = addr[31:8].
- Cold load 0x0000_0104, memory returns a line with word1=0xDEADBEEF, ack after 3 cycles -> one ALLOCATE with mem_addr_o=0x0000_0100 and mem_we_o=0; stall for 5 cycles; cpu_data_o=0xDEADBEEF in the completing cycle.
- Load 0x0000_0108 right after -> hit, no stall, no mem_req_o.
- Store 0x1234_5678 to 0x0000_0104 (hit), then load 0x0000_0204 -> WRITEBACK to 0x0000_0100 with mem_data_o[63:32]=0x12345678, then ALLOCATE from 0x0000_0200.
- Clean-line conflict, load 0x0000_0304 after the above refill -> no WRITEBACK, ALLOCATE only.
- Ack in the first request cycle (0 wait) on both WRITEBACK and ALLOCATE -> each state lasts 1 cycle; total dirty-miss stall is 3 cycles.
- rst_n_i pulsed low during ALLOCATE -> mem_req_o and cpu_stall_o drop asynchronously; a reload of 0x0000_0104 then misses (valid cleared).
